// File: rtl/debug_pkg.sv
// Shared definitions for the debug dump path: FSM state encoding, section
// codes and dump geometry.
package debug_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_PC = 3'd1,
        RD_REQ  = 3'd2,
        RD_CAP  = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5,
        NEXT    = 3'd6,
        FINISH  = 3'd7
    } dump_state_t;

    typedef enum logic [1:0] {
        SEC_PC  = 2'd0,
        SEC_REG = 2'd1,
        SEC_MEM = 2'd2
    } section_t;

    localparam int BYTES_PER_WORD   = 4;
    localparam int TOTAL_DUMP_BYTES = BYTES_PER_WORD * (1 + 32 + 32);

endpackage

// File: rtl/word_byte_sender.sv
// Serialises one word onto the UART TX handshake, LSB first, and pulses
// word_sent once the last byte has been shifted out.
module word_byte_sender
    import debug_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] word_in,
    input  logic                  tx_available,
    input  logic                  tx_done,
    output logic [BYTE_WIDTH-1:0] tx_byte,
    output logic                  tx_signal,
    output logic                  word_sent
);

    dump_state_t           state;
    logic [DATA_WIDTH-1:0] word;
    logic [1:0]            byte_idx;

    // Byte loop: only IDLE, SEND and WAIT_TX of the shared encoding are used here.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            word      <= '0;
            byte_idx  <= 2'd0;
            tx_byte   <= '0;
            tx_signal <= 1'b0;
            word_sent <= 1'b0;
        end else begin
            tx_signal <= 1'b0;
            word_sent <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        word     <= word_in;
                        byte_idx <= 2'd0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_available) begin
                        tx_byte   <= word[BYTE_WIDTH-1:0];
                        tx_signal <= 1'b1;
                        state     <= WAIT_TX;
                    end
                end
                WAIT_TX: begin
                    // tx_done outside this state is deliberately ignored
                    if (tx_done) begin
                        if (byte_idx != 2'(BYTES_PER_WORD - 1)) begin
                            word     <= word >> BYTE_WIDTH;
                            byte_idx <= byte_idx + 2'd1;
                            state    <= SEND;
                        end else begin
                            word_sent <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/debug_dump_tx.sv
// Streams PC, registers 0..N_REGS-1 and memory words 0..N_MEM-1 of the halted
// core to the UART; the byte loop itself lives in word_byte_sender.
module debug_dump_tx
    import debug_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_WIDTH_UART = 8,
    parameter int N_REGS          = 32,
    parameter int N_MEM           = 32,
    parameter int ADDR_WIDTH      = 5
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_start,
    input  logic [DATA_WIDTH-1:0]      i_pc,
    output logic [ADDR_WIDTH-1:0]      o_reg_addr,
    output logic                       o_reg_rd,
    input  logic [DATA_WIDTH-1:0]      i_reg_data,
    output logic [ADDR_WIDTH-1:0]      o_mem_addr,
    output logic                       o_mem_rd,
    input  logic [DATA_WIDTH-1:0]      i_mem_data,
    input  logic                       i_tx_available,
    input  logic                       i_tx_done,
    output logic [DATA_WIDTH_UART-1:0] o_tx_byte,
    output logic                       o_tx_signal,
    output logic                       o_busy,
    output logic                       o_done
);

    dump_state_t           state;
    section_t              section;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_word;
    logic                  word_sent;

    word_byte_sender #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (DATA_WIDTH_UART)
    ) u_sender (
        .clock        (i_clock),
        .reset        (i_reset),
        .load         (load),
        .word_in      (load_word),
        .tx_available (i_tx_available),
        .tx_done      (i_tx_done),
        .tx_byte      (o_tx_byte),
        .tx_signal    (o_tx_signal),
        .word_sent    (word_sent)
    );

    // Section/index sequencer; SEND here means "word handed to the sender, awaiting word_sent".
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state      <= IDLE;
            section    <= SEC_PC;
            idx        <= '0;
            load       <= 1'b0;
            load_word  <= '0;
            o_reg_addr <= '0;
            o_reg_rd   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_rd   <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            load     <= 1'b0;
            o_reg_rd <= 1'b0;
            o_mem_rd <= 1'b0;
            o_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_busy <= 1'b1;
                        state  <= LOAD_PC;
                    end
                end
                LOAD_PC: begin
                    section   <= SEC_PC;
                    load_word <= i_pc;
                    load      <= 1'b1;
                    state     <= SEND;
                end
                RD_REQ: state <= RD_CAP;
                RD_CAP: begin
                    // read data is valid in the cycle after the strobe
                    load_word <= (section == SEC_REG) ? i_reg_data : i_mem_data;
                    load      <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (word_sent) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    case (section)
                        SEC_PC: begin
                            section    <= SEC_REG;
                            idx        <= '0;
                            o_reg_addr <= '0;
                            o_reg_rd   <= 1'b1;
                            state      <= RD_REQ;
                        end
                        SEC_REG: begin
                            if (idx != ADDR_WIDTH'(N_REGS - 1)) begin
                                idx        <= idx + ADDR_WIDTH'(1);
                                o_reg_addr <= idx + ADDR_WIDTH'(1);
                                o_reg_rd   <= 1'b1;
                            end else begin
                                section    <= SEC_MEM;
                                idx        <= '0;
                                o_mem_addr <= '0;
                                o_mem_rd   <= 1'b1;
                            end
                            state <= RD_REQ;
                        end
                        SEC_MEM: begin
                            if (idx != ADDR_WIDTH'(N_MEM - 1)) begin
                                idx        <= idx + ADDR_WIDTH'(1);
                                o_mem_addr <= idx + ADDR_WIDTH'(1);
                                o_mem_rd   <= 1'b1;
                                state      <= RD_REQ;
                            end else begin
                                o_done <= 1'b1;
                                state  <= FINISH;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
                FINISH: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_dump_tx.sv
// Directed bench for debug_dump_tx: UART and sync-read memory models plus
// scenario tasks with inline expected-value comparisons.
module tb_debug_dump_tx;
    import debug_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] pc;
    logic [4:0]  reg_addr;
    logic        reg_rd;
    logic [31:0] reg_data;
    logic [4:0]  mem_addr;
    logic        mem_rd;
    logic [31:0] mem_data;
    logic        tx_available;
    logic        tx_done;
    logic [7:0]  tx_byte;
    logic        tx_signal;
    logic        busy;
    logic        done;

    logic        uart_idle;
    int          uart_cnt;
    logic        hold;
    logic        prev_reg_rd;
    logic        prev_mem_rd;

    logic [7:0]  byte_log[$];
    logic [4:0]  reg_log[$];
    logic [4:0]  mem_log[$];
    logic [4:0]  long_log[$];
    int          done_log[$];

    int n_cmp  = 0;
    int n_fail = 0;

    debug_dump_tx dut (
        .i_clock        (clock),
        .i_reset        (reset),
        .i_start        (start),
        .i_pc           (pc),
        .o_reg_addr     (reg_addr),
        .o_reg_rd       (reg_rd),
        .i_reg_data     (reg_data),
        .o_mem_addr     (mem_addr),
        .o_mem_rd       (mem_rd),
        .i_mem_data     (mem_data),
        .i_tx_available (tx_available),
        .i_tx_done      (tx_done),
        .o_tx_byte      (tx_byte),
        .o_tx_signal    (tx_signal),
        .o_busy         (busy),
        .o_done         (done)
    );

    always #5 clock = ~clock;

    assign tx_available = uart_idle && !hold;

    // Synchronous-read memories: data valid only in the cycle after the strobe.
    always @(posedge clock) begin
        reg_data <= reg_rd ? (32'(reg_addr) * 32'h0101_0101) : 32'hDEAD_BEEF;
        mem_data <= mem_rd ? (32'hA500_0000 | 32'(mem_addr)) : 32'hBAAD_F00D;
    end

    // UART model (done 20 cycles after each start) and output monitor.
    always @(negedge clock) begin
        if (!reset) begin
            uart_cnt  <= 0;
            uart_idle <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (tx_signal) begin
                byte_log.push_back(tx_byte);
                uart_idle <= 1'b0;
                uart_cnt  <= 20;
            end else if (uart_cnt != 0) begin
                uart_cnt <= uart_cnt - 1;
                if (uart_cnt == 1) begin
                    tx_done   <= 1'b1;
                    uart_idle <= 1'b1;
                end
            end
            if (done) done_log.push_back(1);
            if (reg_rd) begin
                if (prev_reg_rd) long_log.push_back(reg_addr);
                else reg_log.push_back(reg_addr);
            end
            if (mem_rd) begin
                if (prev_mem_rd) long_log.push_back(mem_addr);
                else mem_log.push_back(mem_addr);
            end
        end
        prev_reg_rd <= reg_rd;
        prev_mem_rd <= mem_rd;
    end

    function automatic logic [7:0] exp_byte(input int n);
        logic [31:0] w;
        int wi;
        wi = n / 4;
        if (wi == 0) w = 32'h0000_003C;
        else if (wi <= 32) w = 32'(wi - 1) * 32'h0101_0101;
        else w = 32'hA500_0000 | 32'(wi - 33);
        w = w >> (8 * (n % 4));
        return w[7:0];
    endfunction

    task automatic clear_logs();
        byte_log.delete();
        reg_log.delete();
        mem_log.delete();
        long_log.delete();
        done_log.delete();
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 12000; c++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_bytes(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 12000; c++) begin
            @(negedge clock);
            if (byte_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        n_cmp++;
        if ({tx_signal, busy, done, reg_rd, mem_rd} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected 00000", {tx_signal, busy, done, reg_rd, mem_rd});
        end
        n_cmp++;
        if ({tx_byte, reg_addr, mem_addr} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected 0", {tx_byte, reg_addr, mem_addr});
        end
        reset = 1'b1;
        clear_logs();
        repeat (1000) @(negedge clock);
        n_cmp++;
        if (byte_log.size() !== 0) begin
            n_fail++;
            $display("FAIL idle_no_tx: got %0d bytes expected 0", byte_log.size());
        end
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_outputs: got %b expected 00", {busy, done});
        end
    endtask

    task automatic test_full_dump();
        bit ok;
        logic [7:0] first12 [12];
        first12 = '{8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h01, 8'h01, 8'h01, 8'h01};
        clear_logs();
        pulse_start();
        n_cmp++;
        if ({busy, tx_signal} !== 2'b10) begin
            n_fail++;
            $display("FAIL start_busy: got %b expected 10", {busy, tx_signal});
        end
        @(negedge clock);
        n_cmp++;
        if (tx_signal !== 1'b0) begin
            n_fail++;
            $display("FAIL start_latency: got %b expected 0", tx_signal);
        end
        wait_done(ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL full_timeout: got %b expected 1", ok);
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_in_finish: got %b expected 1", busy);
        end
        repeat (20) @(negedge clock);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after: got %b expected 0", busy);
        end
        n_cmp++;
        if (done_log.size() !== 1) begin
            n_fail++;
            $display("FAIL full_done_count: got %0d expected 1", done_log.size());
        end
        n_cmp++;
        if (byte_log.size() !== TOTAL_DUMP_BYTES) begin
            n_fail++;
            $display("FAIL full_count: got %0d expected %0d", byte_log.size(), TOTAL_DUMP_BYTES);
        end
        for (int i = 0; i < 12 && i < byte_log.size(); i++) begin
            n_cmp++;
            if (byte_log[i] !== first12[i]) begin
                n_fail++;
                $display("FAIL first_bytes[%0d]: got %h expected %h", i, byte_log[i], first12[i]);
            end
        end
        for (int i = 0; i < byte_log.size(); i++) begin
            n_cmp++;
            if (byte_log[i] !== exp_byte(i)) begin
                n_fail++;
                $display("FAIL full_byte[%0d]: got %h expected %h", i, byte_log[i], exp_byte(i));
            end
        end
    endtask

    task automatic test_read_timing();
        n_cmp++;
        if (long_log.size() !== 0) begin
            n_fail++;
            $display("FAIL strobe_width: got %0d extra strobe cycles expected 0", long_log.size());
        end
        n_cmp++;
        if (reg_log.size() !== 32 || mem_log.size() !== 32) begin
            n_fail++;
            $display("FAIL strobe_count: got %0d/%0d expected 32/32", reg_log.size(), mem_log.size());
        end
        for (int k = 0; k < reg_log.size(); k++) begin
            n_cmp++;
            if (reg_log[k] !== 5'(k)) begin
                n_fail++;
                $display("FAIL reg_addr[%0d]: got %0d expected %0d", k, reg_log[k], k);
            end
        end
        for (int k = 0; k < mem_log.size(); k++) begin
            n_cmp++;
            if (mem_log[k] !== 5'(k)) begin
                n_fail++;
                $display("FAIL mem_addr[%0d]: got %0d expected %0d", k, mem_log[k], k);
            end
        end
    endtask

    task automatic test_flow_control();
        bit ok;
        clear_logs();
        pulse_start();
        wait_bytes(50, ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL flow_reach: got %b expected 1", ok);
        end
        hold = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            n_cmp++;
            if (tx_signal !== 1'b0) begin
                n_fail++;
                $display("FAIL flow_hold[%0d]: got %b expected 0", c, tx_signal);
            end
        end
        hold = 1'b0;
        wait_done(ok);
        repeat (5) @(negedge clock);
        n_cmp++;
        if (ok !== 1'b1 || byte_log.size() !== TOTAL_DUMP_BYTES) begin
            n_fail++;
            $display("FAIL flow_count: got %0d bytes expected %0d", byte_log.size(), TOTAL_DUMP_BYTES);
        end
        for (int i = 0; i < byte_log.size(); i++) begin
            n_cmp++;
            if (byte_log[i] !== exp_byte(i)) begin
                n_fail++;
                $display("FAIL flow_byte[%0d]: got %h expected %h", i, byte_log[i], exp_byte(i));
            end
        end
    endtask

    task automatic test_start_while_busy();
        bit ok;
        clear_logs();
        pulse_start();
        wait_bytes(45, ok);
        pulse_start();
        wait_done(ok);
        repeat (100) @(negedge clock);
        n_cmp++;
        if (byte_log.size() !== TOTAL_DUMP_BYTES) begin
            n_fail++;
            $display("FAIL busy_start_count: got %0d expected %0d", byte_log.size(), TOTAL_DUMP_BYTES);
        end
        n_cmp++;
        if (done_log.size() !== 1) begin
            n_fail++;
            $display("FAIL busy_start_done: got %0d expected 1", done_log.size());
        end
        n_cmp++;
        if (byte_log.size() > 0 && byte_log[byte_log.size()-1] !== 8'hA5) begin
            n_fail++;
            $display("FAIL busy_start_last: got %h expected a5", byte_log[byte_log.size()-1]);
        end
    endtask

    task automatic test_reset_mid_dump();
        bit ok;
        clear_logs();
        pulse_start();
        wait_bytes(4 + 128 + 22, ok);
        n_cmp++;
        if (ok !== 1'b1 || mem_log.size() !== 6) begin
            n_fail++;
            $display("FAIL mid_reach: got %0d mem reads expected 6", mem_log.size());
        end
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({tx_signal, busy, done, reg_rd, mem_rd} !== 5'b0) begin
            n_fail++;
            $display("FAIL mid_reset_strobes: got %b expected 00000", {tx_signal, busy, done, reg_rd, mem_rd});
        end
        n_cmp++;
        if ({tx_byte, reg_addr, mem_addr} !== 18'h0) begin
            n_fail++;
            $display("FAIL mid_reset_values: got %h expected 0", {tx_byte, reg_addr, mem_addr});
        end
        reset = 1'b1;
        @(negedge clock);
        clear_logs();
        pulse_start();
        wait_done(ok);
        repeat (5) @(negedge clock);
        n_cmp++;
        if (ok !== 1'b1 || byte_log.size() !== TOTAL_DUMP_BYTES) begin
            n_fail++;
            $display("FAIL restart_count: got %0d expected %0d", byte_log.size(), TOTAL_DUMP_BYTES);
        end
        for (int i = 0; i < byte_log.size(); i++) begin
            n_cmp++;
            if (byte_log[i] !== exp_byte(i)) begin
                n_fail++;
                $display("FAIL restart_byte[%0d]: got %h expected %h", i, byte_log[i], exp_byte(i));
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        hold  = 1'b0;
        pc    = 32'h0000_003C;
        test_reset();
        test_full_dump();
        test_read_timing();
        test_flow_control();
        test_start_while_busy();
        test_reset_mid_dump();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_dump_tx.md
Name: debug_dump_tx

Overview:
- Debug-unit stage directly downstream of the halted MIPS core and upstream of the UART transmitter.
- On a start pulse it streams the machine state to the host over UART: PC, then registers 0..31, then data-memory words 0..31.
- Every word is sent as 4 bytes, LSB first, for a total of 260 bytes.
- It drives the register-file and data-memory debug read ports and the UART TX handshake.

Parameters:
DATA_WIDTH, 32, width of PC, register and memory words
DATA_WIDTH_UART, 8, UART byte width
N_REGS, 32, number of registers dumped
N_MEM, 32, number of data-memory words dumped
ADDR_WIDTH, 5, debug read address width (log2 of N_REGS and N_MEM)

Ports:
i_clock  in  1  system clock; all logic on its rising edge
i_reset  in  1  synchronous, active-low reset
i_start  in  1  one-cycle pulse: begin dump; sampled only in IDLE
i_pc  in  DATA_WIDTH  current PC of the halted core
o_reg_addr  out  ADDR_WIDTH  register-file debug read address
o_reg_rd  out  1  register read strobe
i_reg_data  in  DATA_WIDTH  register data, valid 1 cycle after o_reg_rd
o_mem_addr  out  ADDR_WIDTH  data-memory debug read address
o_mem_rd  out  1  memory read strobe
i_mem_data  in  DATA_WIDTH  memory data, valid 1 cycle after o_mem_rd
i_tx_available  in  1  UART TX idle and ready to accept a byte
i_tx_done  in  1  one-cycle pulse: current byte fully shifted out
o_tx_byte  out  DATA_WIDTH_UART  byte to transmit
o_tx_signal  out  1  one-cycle TX start pulse
o_busy  out  1  high from the cycle after start through FINISH
o_done  out  1  one-cycle pulse at end of dump

Behaviour:
- Reset (i_reset==0 at a clock edge, including mid-dump): state IDLE; all outputs 0; counters and shift word cleared. A byte already in flight in the UART is abandoned; the block does not wait for i_tx_done.
- States: IDLE, LOAD_PC, RD_REQ, RD_CAP, SEND, WAIT_TX, NEXT, FINISH.
- IDLE: o_busy=0. If i_start=1 -> LOAD_PC. Any i_start outside IDLE is ignored.
- LOAD_PC: word<=i_pc; section<=PC; byte_idx<=0 -> SEND. Latency from i_start to the first o_tx_signal is at least 2 cycles.
- RD_REQ: drive addr=idx and the strobe of the current section (REG or MEM), 1 cycle -> RD_CAP.
- RD_CAP: word<=i_reg_data or i_mem_data; byte_idx<=0 -> SEND.
- SEND: wait for i_tx_available=1. Then o_tx_byte=word[7:0] and o_tx_signal=1 for exactly one cycle -> WAIT_TX. o_tx_byte holds its value until the next SEND.
- WAIT_TX: wait for i_tx_done.
  - If byte_idx<3: word<=word>>8; byte_idx++ -> SEND.
  - If byte_idx==3 -> NEXT.
- NEXT:
  - PC -> section REG, idx=0 -> RD_REQ.
  - REG with idx<N_REGS-1: idx++ -> RD_REQ.
  - REG with idx==N_REGS-1: section MEM, idx=0 -> RD_REQ.
  - MEM with idx<N_MEM-1: idx++ -> RD_REQ.
  - MEM with idx==N_MEM-1 -> FINISH.
- FINISH: o_done=1 for one cycle -> IDLE.
- Counters: idx is ADDR_WIDTH bits and never wraps implicitly; the terminal compare is explicit. byte_idx is 2 bits.
- i_tx_done arriving outside WAIT_TX is ignored.
- Strobes o_reg_rd and o_mem_rd are high only in RD_REQ.
- Byte order on the wire: PC[7:0], PC[15:8], PC[23:16], PC[31:24], R0[7:0], ..., R31[31:24], M0[7:0], ..., M31[31:24].

Decomposition:
- Shared package debug_pkg:
  - state encoding
  - section codes PC/REG/MEM
  - BYTES_PER_WORD=4
  - TOTAL_DUMP_BYTES=260
- Sub-module word_byte_sender: takes a word plus a load strobe, runs the SEND/WAIT_TX loop over 4 bytes, and returns a word_sent pulse. The top FSM handles section and index sequencing.

Test Plan:
- Reset then idle: i_reset=0 for 2 cycles, then 1; no start -> all outputs 0, no o_tx_signal for 1000 cycles.
- Full dump: i_pc=0x0000003C; reg k=k*0x01010101; mem k=0xA5000000|k; UART model with done 20 cycles after each start -> 260 bytes in exact order, first bytes 3C 00 00 00 00 00 00 00 01 01 01 01; o_done once; o_busy low afterwards.
- Flow control: hold i_tx_available=0 for 50 cycles mid-dump -> no o_tx_signal during the hold; the byte sequence is unchanged.
- Start while busy: pulse i_start during register 10 -> ignored; exactly 260 bytes and one o_done.
- Reset mid-dump: assert i_reset during memory word 5 -> next cycle IDLE with outputs 0; a new i_start restarts from PC byte 0.
- Read timing: check o_reg_addr=k with o_reg_rd high for exactly 1 cycle per register, and the captured word equals i_reg_data from the following cycle.
